deserializer_8b10b: RTL

- Receive-side counterpart of the 8b/10b serializer.
- Samples a serial bit stream on the bit clock and finds symbol alignment by hunting for the K28.5 comma.
- Assembles 10-bit code groups, decodes them to 8-bit data, and tracks running disparity and error status.
- Sits between the link input pin/CDR flop and the parallel receive datapath.

---
 rtl/deserializer_8b10b.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/deserializer_8b10b.sv
// 8b/10b receiver: hunts for the K28.5 comma on the serial bit stream, then decodes each
// aligned 10-bit code group to a byte with running-disparity and code-error tracking.
module deserializer_8b10b #(
   parameter int P_LOSS_CNT  = 4,
   parameter int P_ERR_CNT_W = 8
) (
   input  logic                   i_Clk,
   input  logic                   i_rst_n,
   input  logic                   i_Ser_Data,
   input  logic                   i_Clr_Err,
   output logic [7:0]             o_Data,
   output logic                   o_Valid,
   output logic                   o_K,
   output logic                   o_Code_Err,
   output logic                   o_Disp_Err,
   output logic signed [1:0]      o_RD,
   output logic                   o_Locked,
   output logic [9:0]             o_10B,
   output logic [P_ERR_CNT_W-1:0] o_Err_Count
);

   typedef enum logic {HUNT, LOCKED} state_t;

   localparam logic [9:0]        COMMA_NEG = 10'b0011111010;
   localparam logic [9:0]        COMMA_POS = 10'b1100000101;
   localparam logic [7:0]        K28_5     = 8'hBC;
   localparam logic [3:0]        LOSS_LAST = 4'(P_LOSS_CNT - 1);
   localparam logic signed [1:0] RD_POS    = 2'sb01;
   localparam logic signed [1:0] RD_NEG    = 2'sb11;
   localparam logic [P_ERR_CNT_W-1:0] ERR_MAX = {P_ERR_CNT_W{1'b1}};

   // 6b sub-block {abcdei} -> {legal, EDCBA}; both disparity forms accepted
   function automatic logic [5:0] dec6(input logic [5:0] c);
      case (c)
         6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
         6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
         6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
         6'b110001:            dec6 = {1'b1, 5'd3};
         6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
         6'b101001:            dec6 = {1'b1, 5'd5};
         6'b011001:            dec6 = {1'b1, 5'd6};
         6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
         6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
         6'b100101:            dec6 = {1'b1, 5'd9};
         6'b010101:            dec6 = {1'b1, 5'd10};
         6'b110100:            dec6 = {1'b1, 5'd11};
         6'b001101:            dec6 = {1'b1, 5'd12};
         6'b101100:            dec6 = {1'b1, 5'd13};
         6'b011100:            dec6 = {1'b1, 5'd14};
         6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
         6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
         6'b100011:            dec6 = {1'b1, 5'd17};
         6'b010011:            dec6 = {1'b1, 5'd18};
         6'b110010:            dec6 = {1'b1, 5'd19};
         6'b001011:            dec6 = {1'b1, 5'd20};
         6'b101010:            dec6 = {1'b1, 5'd21};
         6'b011010:            dec6 = {1'b1, 5'd22};
         6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
         6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
         6'b100110:            dec6 = {1'b1, 5'd25};
         6'b010110:            dec6 = {1'b1, 5'd26};
         6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
         6'b001110:            dec6 = {1'b1, 5'd28};
         6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
         6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
         6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
         default:              dec6 = 6'b0;
      endcase
   endfunction

   // 4b sub-block {fghj} -> {legal, HGF}; primary and alternate D.x.7 both give 111
   function automatic logic [3:0] dec4(input logic [3:0] c);
      case (c)
         4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
         4'b1001:                            dec4 = {1'b1, 3'd1};
         4'b0101:                            dec4 = {1'b1, 3'd2};
         4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
         4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
         4'b1010:                            dec4 = {1'b1, 3'd5};
         4'b0110:                            dec4 = {1'b1, 3'd6};
         4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
         default:                            dec4 = 4'b0;
      endcase
   endfunction

   function automatic logic [3:0] ones10(input logic [9:0] w);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 10; i++) n = n + {3'd0, w[i]};
      return n;
   endfunction

   function automatic logic disp_bad(input logic [3:0] n, input logic signed [1:0] rd);
      return (n < 4'd4) || (n > 4'd6) ||
             ((n == 4'd6) && (rd == RD_POS)) ||
             ((n == 4'd4) && (rd == RD_NEG));
   endfunction

   function automatic logic signed [1:0] rd_update(input logic [3:0] n,
                                                    input logic signed [1:0] rd);
      if (n > 4'd5)      return RD_POS;
      else if (n < 4'd5) return RD_NEG;
      else               return rd;
   endfunction

   function automatic logic [P_ERR_CNT_W-1:0] sat_inc(input logic [P_ERR_CNT_W-1:0] c);
      return (c == ERR_MAX) ? c : c + 1'b1;
   endfunction

   state_t     state;
   logic [9:1] sr;       // oldest bit of the window is never needed again, so only 9 are kept
   logic [3:0] bit_cnt;
   logic [3:0] loss_cnt;

   logic [9:0]        word_p0;
   logic [5:0]        d6_p0;
   logic [3:0]        d4_p0;
   logic [3:0]        ones_p0;
   logic              comma_neg_p0;
   logic              comma_pos_p0;
   logic              is_comma_p0;
   logic              code_err_p0;
   logic              disp_err_p0;
   logic [7:0]        data_p0;
   logic signed [1:0] rd_next_p0;

   // Stage p0: decode the window as it will look after this edge's bit is shifted in
   always_comb begin
      word_p0      = {i_Ser_Data, sr};
      d6_p0        = dec6(word_p0[9:4]);
      d4_p0        = dec4(word_p0[3:0]);
      ones_p0      = ones10(word_p0);
      comma_neg_p0 = (word_p0 == COMMA_NEG);
      comma_pos_p0 = (word_p0 == COMMA_POS);
      is_comma_p0  = comma_neg_p0 || comma_pos_p0;
      code_err_p0  = !is_comma_p0 && !(d6_p0[5] && d4_p0[3]);
      if (is_comma_p0)      data_p0 = K28_5;
      else if (code_err_p0) data_p0 = 8'h00;
      else                  data_p0 = {d4_p0[2:0], d6_p0[4:0]};
      disp_err_p0  = disp_bad(ones_p0, o_RD);
      rd_next_p0   = rd_update(ones_p0, o_RD);
   end

   // Stage p1: alignment FSM and registered symbol outputs
   always_ff @(posedge i_Clk) begin
      if (!i_rst_n) begin
         state       <= HUNT;
         sr          <= '0;
         bit_cnt     <= '0;
         loss_cnt    <= '0;
         o_Data      <= '0;
         o_Valid     <= 1'b0;
         o_K         <= 1'b0;
         o_Code_Err  <= 1'b0;
         o_Disp_Err  <= 1'b0;
         o_RD        <= RD_NEG;
         o_Locked    <= 1'b0;
         o_10B       <= '0;
         o_Err_Count <= '0;
      end else begin
         sr      <= word_p0[9:1];
         o_Valid <= 1'b0;
         case (state)
            HUNT: begin
               if (is_comma_p0) begin
                  state      <= LOCKED;
                  bit_cnt    <= '0;
                  loss_cnt   <= '0;
                  o_Valid    <= 1'b1;
                  o_K        <= 1'b1;
                  o_Data     <= K28_5;
                  o_Code_Err <= 1'b0;
                  o_Disp_Err <= 1'b0;
                  o_10B      <= word_p0;
                  o_RD       <= comma_neg_p0 ? RD_POS : RD_NEG;
                  o_Locked   <= 1'b1;
               end
            end
            LOCKED: begin
               bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
               if (bit_cnt == 4'd9) begin
                  o_Valid    <= 1'b1;
                  o_K        <= is_comma_p0;
                  o_Data     <= data_p0;
                  o_Code_Err <= code_err_p0;
                  o_Disp_Err <= disp_err_p0;
                  o_10B      <= word_p0;
                  o_RD       <= rd_next_p0;
                  if (code_err_p0 || disp_err_p0) o_Err_Count <= sat_inc(o_Err_Count);
                  if (code_err_p0) begin
                     if (loss_cnt == LOSS_LAST) begin
                        state    <= HUNT;
                        o_Locked <= 1'b0;
                        loss_cnt <= '0;
                     end else begin
                        loss_cnt <= loss_cnt + 4'd1;
                     end
                  end else begin
                     loss_cnt <= '0;
                  end
               end
            end
            default: state <= HUNT;
         endcase
         if (i_Clr_Err) o_Err_Count <= '0;
      end
   end

endmodule
